// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   rx_state_t    : receiver FSM states.
//   BAUD_CNT_DFLT : clocks per bit at 50 MHz / 19200 baud. The transmitter
//                   uses the same value.
package uart_pkg;

  localparam int BAUD_CNT_DFLT = 2604;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_baud_tmr.sv
// Loadable down-counter used as the receiver baud timer.
//   clk, rst_n : system clock, asynchronous active-low reset
//   load       : load a new interval (has priority over counting)
//   load_val   : interval length in clocks (must be >= 1)
//   expire     : single-cycle pulse, load_val clocks after the load
// The counter holds at 0 instead of wrapping. Loading load_val-1 makes
// a reload on the expire cycle give an exact period of load_val clocks.
module uart_baud_tmr #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt;
  logic         armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (load) begin
      cnt   <= load_val - W'(1);
      armed <= 1'b1;
    end else begin
      if (cnt != '0) cnt <= cnt - W'(1);
      if (expire)    armed <= 1'b0;
    end
  end

  // armed keeps the idle count of 0 from looking like a fresh expiry.
  always_comb begin
    expire = armed && (cnt == '0);
  end

endmodule

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver for the command/auth path.
//   clk, rst_n : system clock, asynchronous active-low reset
//   RX         : asynchronous serial line, idles high
//   clr_rdy    : consumer acknowledge pulse
//   rx_data    : last good byte received
//   rdy        : rx_data is valid and not yet consumed
//   frm_err    : last frame had a low stop bit
//   ovr_err    : an unconsumed byte was overwritten
// Handshake: rdy rises when a good byte lands in rx_data. rx_data is
// stable while rdy is high until the next completion. A clr_rdy pulse
// drops rdy and the error flags on the next clock. A completion in the
// same cycle as clr_rdy wins: rdy stays high, no overrun is flagged.
module uart_cmd_rx
  import uart_pkg::*;
#(
  parameter int BAUD_CNT = BAUD_CNT_DFLT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       ovr_err
);

  localparam logic [11:0] BAUD_FULL = 12'(BAUD_CNT);
  localparam logic [11:0] BAUD_HALF = 12'(BAUD_CNT / 2);

  rx_state_t   state, nxt_state;
  logic        rx_meta, rx_sync, rx_prev, fall_q;
  logic [3:0]  bit_cnt;
  logic [8:0]  shreg;
  logic        tmr_load, expire;
  logic [11:0] tmr_val;
  logic        shift_en, bit_inc, bit_clr, done_good, done_bad;

  // Two-flop synchronizer plus a registered falling-edge detect.
  // All preset high so reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
      fall_q  <= 1'b0;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      fall_q  <= rx_prev & ~rx_sync;
    end
  end

  uart_baud_tmr #(.W(12)) u_baud_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (expire)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt_state;
  end

  // FSM: next state
  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:  if (fall_q) nxt_state = START;
      START: if (expire) nxt_state = rx_sync ? IDLE : DATA;
      DATA:  if (expire && (bit_cnt == 4'd7)) nxt_state = STOP;
      STOP:  if (expire) nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    tmr_load  = 1'b0;
    tmr_val   = BAUD_FULL;
    shift_en  = 1'b0;
    bit_inc   = 1'b0;
    bit_clr   = 1'b0;
    done_good = 1'b0;
    done_bad  = 1'b0;
    case (state)
      IDLE: begin
        if (fall_q) begin
          tmr_load = 1'b1;
          tmr_val  = BAUD_HALF;
          bit_clr  = 1'b1;
        end
      end
      START: begin
        // Start bit is kept in the shift register so the frame check
        // covers both framing bits.
        if (expire && !rx_sync) begin
          tmr_load = 1'b1;
          shift_en = 1'b1;
        end
      end
      DATA: begin
        if (expire) begin
          tmr_load = 1'b1;
          shift_en = 1'b1;
          bit_inc  = 1'b1;
        end
      end
      STOP: begin
        if (expire) begin
          done_good = rx_sync & ~shreg[0];
          done_bad  = ~(rx_sync & ~shreg[0]);
        end
      end
      default: ;
    endcase
  end

  // Shift register (LSB first, shifting right) and bit counter.
  // After start + 8 data shifts: shreg[0] = start bit, shreg[8:1] = byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      if (shift_en) shreg <= {rx_sync, shreg[8:1]};
      if (bit_clr)      bit_cnt <= '0;
      else if (bit_inc) bit_cnt <= bit_cnt + 4'd1;
    end
  end

  // Consumer-facing flags and data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data <= 8'h00;
      rdy     <= 1'b0;
      frm_err <= 1'b0;
      ovr_err <= 1'b0;
    end else if (done_good) begin
      rx_data <= shreg[8:1];
      rdy     <= 1'b1;
      frm_err <= 1'b0;
      // Overrun only when the old byte is still unconsumed this cycle.
      ovr_err <= (rdy | ovr_err) & ~clr_rdy;
    end else if (done_bad) begin
      frm_err <= 1'b1;
      if (clr_rdy) begin
        rdy     <= 1'b0;
        ovr_err <= 1'b0;
      end
    end else if (clr_rdy) begin
      rdy     <= 1'b0;
      frm_err <= 1'b0;
      ovr_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
module tb_uart_cmd_rx;
  import uart_pkg::*;

  localparam int B   = 64;                // short bit time keeps runtime low
  localparam int LAT = (19 * B) / 2 + 4;  // nominal RX fall -> rdy clocks

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       RX = 1'b1;
  logic       clr_rdy = 1'b0;
  logic [7:0] rx_data;
  logic       rdy, frm_err, ovr_err;

  uart_cmd_rx #(.BAUD_CNT(B)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (RX),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rdy     (rdy),
    .frm_err (frm_err),
    .ovr_err (ovr_err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] m_data;
  logic       m_rdy, m_frm, m_ovr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_data = 8'h00;
    m_rdy  = 1'b0;
    m_frm  = 1'b0;
    m_ovr  = 1'b0;
    exp_q.delete();
  endfunction

  // Effect of one finished frame on the consumer view.
  function automatic void model_frame(input logic [7:0] b, input logic stop, input bit clr_same);
    if (stop) begin
      m_ovr  = clr_same ? 1'b0 : (m_rdy | m_ovr);
      m_data = b;
      m_rdy  = 1'b1;
      m_frm  = 1'b0;
      exp_q.push_back(b);
    end else begin
      m_frm = 1'b1;
      if (clr_same) begin
        m_rdy = 1'b0;
        m_ovr = 1'b0;
      end
    end
  endfunction

  function automatic void model_clr();
    m_rdy = 1'b0;
    m_frm = 1'b0;
    m_ovr = 1'b0;
  endfunction

  task automatic check_flags(input string tag);
    check({tag, "_rdy"},  rdy,     m_rdy);
    check({tag, "_frm"},  frm_err, m_frm);
    check({tag, "_ovr"},  ovr_err, m_ovr);
    check({tag, "_data"}, rx_data, m_data);
  endtask

  // ---------------- drivers ----------------
  // Drives one 10-bit frame; lat = first negedge count at which rdy is seen.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit clr_same,
                            output int lat);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    lat  = -1;
    for (int t = 0; t < 10 * B; t++) begin
      @(negedge clk);
      if (lat < 0 && rdy === 1'b1) lat = t;
      RX      = bits[t / B];
      clr_rdy = clr_same && (t == LAT - 1);
    end
    @(negedge clk);
    RX      = 1'b1;
    clr_rdy = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] b, input logic stop, input bit clr_same,
                           input string tag);
    bit         was_rdy;
    int         lat;
    logic [7:0] exp_b;
    was_rdy = m_rdy;
    send_frame(b, stop, clr_same, lat);
    model_frame(b, stop, clr_same);
    if (stop) begin
      exp_b = exp_q.pop_front();
      check({tag, "_sb"}, rx_data, exp_b);
      if (!was_rdy)
        check($sformatf("%s_lat%0d", tag, lat), (lat >= LAT - 1 && lat <= LAT + 1), 1);
    end
    check_flags(tag);
  endtask

  task automatic pulse_clr(input string tag);
    @(negedge clk);
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
    model_clr();
    check_flags(tag);
  endtask

  task automatic glitch(input int len, input string tag);
    @(negedge clk);
    RX = 1'b0;
    repeat (len) @(negedge clk);
    RX = 1'b1;
    repeat (B / 2 + 12) @(negedge clk);
    check({tag, "_idle"}, dut.state, IDLE);
    check_flags(tag);
  endtask

  task automatic reset_mid_frame();
    logic [9:0] bits;
    bits = {1'b1, 8'hFF, 1'b0};
    for (int t = 0; t < 10 * B; t++) begin
      @(negedge clk);
      RX = bits[t / B];
      if (t == 4 * B + B / 2) begin       // middle of data bit 3
        rst_n = 1'b0;
        #1;
        model_reset();
        check_flags("rst_async");
      end
      if (t == 4 * B + B / 2 + 3) rst_n = 1'b1;
    end
    @(negedge clk);
    RX = 1'b1;
    repeat (B) @(negedge clk);
    check_flags("rst_tail");
  endtask

  // ---------------- sequence ----------------
  initial begin
    logic [7:0] rb;
    logic       rstop;
    bit         rclr;
    model_reset();
    repeat (3) @(negedge clk);
    check_flags("reset");
    check("reset_state", dut.state, IDLE);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    run_frame(8'h47, 1'b1, 1'b0, "g47");
    pulse_clr("clr47");

    run_frame(8'h53, 1'b1, 1'b0, "b2b_53");
    pulse_clr("clr53");
    run_frame(8'h00, 1'b1, 1'b0, "b2b_00");
    pulse_clr("clr00");

    glitch(14, "glitch");
    run_frame(8'hA5, 1'b1, 1'b0, "after_glitch");
    pulse_clr("clrA5");

    run_frame(8'h3C, 1'b0, 1'b0, "frm_bad");
    run_frame(8'h5A, 1'b1, 1'b0, "frm_good");
    pulse_clr("clr5A");

    run_frame(8'h11, 1'b1, 1'b0, "ovr_11");
    run_frame(8'h22, 1'b1, 1'b0, "ovr_22");
    pulse_clr("clr_ovr");
    run_frame(8'h33, 1'b1, 1'b0, "same_33");
    run_frame(8'h44, 1'b1, 1'b1, "same_44");
    pulse_clr("clr_same");

    run_frame(8'h96, 1'b1, 1'b0, "pre_rst");
    reset_mid_frame();
    run_frame(8'h5A, 1'b1, 1'b0, "post_rst");
    pulse_clr("clr_post");

    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 5) == 0) glitch($urandom_range(1, B / 2 - 4), "rnd_glitch");
      rb    = 8'($urandom_range(0, 255));
      rstop = ($urandom_range(0, 5) != 0);
      rclr  = ($urandom_range(0, 4) == 0);
      run_frame(rb, rstop, rclr, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 1) pulse_clr($sformatf("rnd_clr%0d", i));
      repeat ($urandom_range(1, B)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
